// File: rtl/priv_1_12_trap_sequencer_if.sv
// priv_1_12_trap_sequencer_if
//   Groups the trap/return request inputs, the privilege-block redirect
//   strobe, the fetch redirect handshake and the sequencer status outputs.
//   The master side is the pipeline/privilege environment; the slave side is
//   the trap sequencer itself.
//   Requests : trap_req, ret_req, ex_valid, ex_pc, fetch_pc
//   Memory   : dmem_busy, imem_busy
//   Priv     : insert_pc, priv_pc -> pipe_clear, epc
//   Fetch    : stall_fetch, flush_younger, redirect_valid, redirect_pc <- fetch_ack
//   Status   : drain_timeout, busy
interface priv_1_12_trap_sequencer_if;
  logic        trap_req;
  logic        ret_req;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] fetch_pc;
  logic        dmem_busy;
  logic        imem_busy;
  logic        insert_pc;
  logic [31:0] priv_pc;
  logic        fetch_ack;
  logic        pipe_clear;
  logic [31:0] epc;
  logic        flush_younger;
  logic        stall_fetch;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        drain_timeout;
  logic        busy;

  modport master (
    output trap_req, ret_req, ex_valid, ex_pc, fetch_pc, dmem_busy, imem_busy,
           insert_pc, priv_pc, fetch_ack,
    input  pipe_clear, epc, flush_younger, stall_fetch, redirect_valid,
           redirect_pc, drain_timeout, busy
  );

  modport slave (
    input  trap_req, ret_req, ex_valid, ex_pc, fetch_pc, dmem_busy, imem_busy,
           insert_pc, priv_pc, fetch_ack,
    output pipe_clear, epc, flush_younger, stall_fetch, redirect_valid,
           redirect_pc, drain_timeout, busy
  );
endinterface

// File: rtl/priv_1_12_trap_sequencer.sv
// priv_1_12_trap_sequencer
//   Sequences the pipeline through a trap or xRET: capture epc, drain
//   outstanding memory traffic, hand the drained pipeline to the privilege
//   block, then issue its redirect PC toward fetch and wait for acceptance.
//   CLK  : core clock
//   nRST : asynchronous active-low reset
//   bus  : request/redirect/handshake signals (see the interface file)
//
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   ST_IDLE     | waiting for trap_req/ret_req
//   ST_DRAIN    | fetch stalled, younger stages flushed, memory settling
//   ST_REDIRECT | pipe_clear to privilege block, waiting for insert_pc
//   ST_REFILL   | redirect_pc offered to fetch, waiting for fetch_ack
module priv_1_12_trap_sequencer #(
  parameter int DRAIN_TIMEOUT = 64
) (
  input logic                      CLK,
  input logic                      nRST,
  priv_1_12_trap_sequencer_if.slave bus
);

  localparam int CNT_W = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_REDIRECT,
    ST_REFILL
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       epc_q, epc_d;
  logic [31:0]       redirect_pc_q, redirect_pc_d;
  logic              redirect_valid_q, redirect_valid_d;
  logic              drain_timeout_q, drain_timeout_d;

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    epc_d            = epc_q;
    redirect_pc_d    = redirect_pc_q;
    redirect_valid_d = redirect_valid_q;
    drain_timeout_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        // Trap wins over a simultaneous return, so epc is captured then too.
        if (bus.trap_req) begin
          epc_d = bus.ex_valid ? bus.ex_pc : bus.fetch_pc;
        end
        if (bus.trap_req || bus.ret_req) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (!bus.dmem_busy && !bus.imem_busy) begin
          state_d = ST_REDIRECT;
        end else if (cnt_q == CNT_LAST) begin
          state_d         = ST_REDIRECT;
          drain_timeout_d = 1'b1;
        end
      end
      ST_REDIRECT: begin
        if (bus.insert_pc) begin
          redirect_pc_d    = bus.priv_pc;
          redirect_valid_d = 1'b1;
          state_d          = ST_REFILL;
        end
      end
      ST_REFILL: begin
        if (bus.fetch_ack) begin
          redirect_valid_d = 1'b0;
          state_d          = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q          <= ST_IDLE;
      cnt_q            <= '0;
      epc_q            <= '0;
      redirect_pc_q    <= '0;
      redirect_valid_q <= 1'b0;
      drain_timeout_q  <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      epc_q            <= epc_d;
      redirect_pc_q    <= redirect_pc_d;
      redirect_valid_q <= redirect_valid_d;
      drain_timeout_q  <= drain_timeout_d;
    end
  end

  // flush_younger must already be high in the request cycle so the
  // instructions behind the trapping one never commit.
  assign bus.flush_younger  = (state_q == ST_DRAIN) ||
                              ((state_q == ST_IDLE) && (bus.trap_req || bus.ret_req));
  assign bus.stall_fetch    = (state_q == ST_DRAIN) || (state_q == ST_REDIRECT);
  assign bus.pipe_clear     = (state_q == ST_REDIRECT);
  assign bus.busy           = (state_q != ST_IDLE);
  assign bus.epc            = epc_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.drain_timeout  = drain_timeout_q;

endmodule

// File: doc/priv_1_12_trap_sequencer.md
Name: priv_1_12_trap_sequencer

Overview:
- Pipeline-side counterpart of the privilege block's pipe_ctrl path. It consumes trap/return requests and the insert_pc/priv_pc redirect, and sequences the pipeline through capture-epc, drain, redirect and refill.
- It produces pipe_clear and epc for the privilege block, plus stage flushes, fetch stall and a valid/ack PC redirect toward fetch.
- Sits between the hazard unit and the privilege block in the 1.12 pipeline.

Parameters:
DRAIN_TIMEOUT, 64, max cycles spent in DRAIN before forcing completion (>=2)
CNT_W, $clog2(DRAIN_TIMEOUT+1), drain counter width (derived, not overridden)

Ports:
CLK  input  1  core clock
nRST  input  1  asynchronous active-low reset
trap_req  input  1  interrupt/exception accepted by privilege block (intr)
ret_req  input  1  mret|sret|uret reached execute
ex_valid  input  1  execute stage holds a real instruction
ex_pc  input  32  PC of instruction in execute
fetch_pc  input  32  PC fetch would issue next
dmem_busy  input  1  data memory request outstanding
imem_busy  input  1  instruction memory request outstanding
insert_pc  input  1  privilege block redirect strobe
priv_pc  input  32  redirect target (trap vector or xepc)
fetch_ack  input  1  fetch accepted redirect_pc
pipe_clear  output  1  pipeline drained, privilege block may update CSRs and redirect
epc  output  32  captured exception PC
flush_younger  output  1  flush IF/ID and ID/EX
stall_fetch  output  1  block fetch issue
redirect_valid  output  1  redirect_pc valid toward fetch
redirect_pc  output  32  new fetch PC
drain_timeout  output  1  one-cycle pulse: drain forced by timeout
busy  output  1  state != IDLE

Behaviour:
- Reset (async, nRST=0): state IDLE, all outputs 0, epc=0, redirect_pc=0, counter=0. Reset mid-sequence aborts to IDLE immediately; no redirect is issued.
- States: IDLE, DRAIN, REDIRECT, REFILL. Two-process FSM; all outputs except flush_younger are registered or pure state decodes.
- IDLE:
  - trap_req or ret_req -> DRAIN next cycle; flush_younger=1 combinationally in the request cycle.
  - On trap_req, epc <= ex_valid ? ex_pc : fetch_pc. On ret_req alone, epc is unchanged.
  - trap_req and ret_req together: trap has priority and epc is captured.
  - Counter cleared.
- DRAIN:
  - stall_fetch=1, flush_younger=1, counter increments each cycle (saturating).
  - If !dmem_busy && !imem_busy -> REDIRECT.
  - Else if counter == DRAIN_TIMEOUT-1 -> REDIRECT with drain_timeout pulsed for that one transition cycle.
  - Minimum DRAIN residency is 1 cycle.
- REDIRECT:
  - pipe_clear=1, stall_fetch=1, held until insert_pc.
  - insert_pc -> redirect_pc <= priv_pc, redirect_valid <= 1, -> REFILL.
  - No timeout in REDIRECT.
- REFILL:
  - redirect_valid=1 (held with redirect_pc stable), stall_fetch=0, pipe_clear=0.
  - fetch_ack -> redirect_valid <= 0, -> IDLE.
  - fetch_ack in the first REFILL cycle is legal.
- Ignored inputs:
  - trap_req/ret_req outside IDLE are ignored (the privilege block holds intr until serviced).
  - insert_pc outside REDIRECT is ignored.
  - fetch_ack outside REFILL is ignored.
- busy = (state != IDLE).
- Latency, no memory traffic: request cycle 0; DRAIN cycle 1; pipe_clear high cycle 2; insert_pc at cycle 2 gives redirect_valid at cycle 3; fetch_ack at cycle 3 gives IDLE at cycle 4. Back-to-back: a new request is accepted in the cycle IDLE is re-entered.
- PCs are 32-bit, passed through unmodified. No alignment is enforced here; misalignment is the handler's concern.

Test Plan:
1. Interrupt, idle memory: ex_valid=1, ex_pc=0x0000_0100, trap_req pulse at cycle 0; insert_pc at cycle 2 with priv_pc=0x0000_0800; fetch_ack at cycle 3 -> epc=0x100 from cycle 1; pipe_clear high exactly cycle 2; redirect_valid/redirect_pc=0x800 at cycle 3; busy low at cycle 4.
2. Drain wait: dmem_busy=1 for 5 cycles after request -> DRAIN held 5 cycles, pipe_clear rises the cycle after dmem_busy drops; drain_timeout never pulses.
3. Timeout: DRAIN_TIMEOUT=8, dmem_busy stuck 1 -> after 8 DRAIN cycles state REDIRECT, drain_timeout single-cycle pulse, pipe_clear asserted.
4. Bubble plus priority: ex_valid=0, fetch_pc=0x0000_0204, trap_req and ret_req same cycle -> epc=0x204. A later ret_req alone leaves epc unchanged; redirect_pc=priv_pc.
5. Handshake holds: redirect_valid asserted, fetch_ack withheld 4 cycles -> redirect_valid and redirect_pc stable for 4 cycles. A second trap_req during this window is ignored; drop occurs the cycle after fetch_ack.
6. Async reset mid-REDIRECT: nRST low between clock edges -> all outputs 0 immediately. After release, insert_pc produces no redirect_valid; state IDLE.
